// File: rtl/desnorm_scheduler_if.sv
// desnorm_scheduler_if -- handshake and datapath bundle for desnorm_scheduler.
//   Input side  : in_valid/in_ready, i_fix/v_fix (fixed-point sample pair)
//   Datapath    : f_i/f_v operands, begin_i/begin_v start pulses, rst_dp,
//                 ack_i/ack_v level done, result_i/result_v
//   Output side : out_valid/out_ready, out_i/out_v, timeout_err
// Modports: slave = scheduler side, master = environment (source/datapath/sink).
interface desnorm_scheduler_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] i_fix;
  logic [W-1:0] v_fix;
  logic [W-1:0] f_i;
  logic [W-1:0] f_v;
  logic         begin_i;
  logic         begin_v;
  logic         rst_dp;
  logic         ack_i;
  logic         ack_v;
  logic [W-1:0] result_i;
  logic [W-1:0] result_v;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_i;
  logic [W-1:0] out_v;
  logic         timeout_err;

  modport slave (
    input  in_valid, i_fix, v_fix, ack_i, ack_v, result_i, result_v, out_ready,
    output in_ready, f_i, f_v, begin_i, begin_v, rst_dp, out_valid, out_i, out_v,
           timeout_err
  );

  modport master (
    output in_valid, i_fix, v_fix, ack_i, ack_v, result_i, result_v, out_ready,
    input  in_ready, f_i, f_v, begin_i, begin_v, rst_dp, out_valid, out_i, out_v,
           timeout_err
  );
endinterface

// File: rtl/desnorm_scheduler.sv
// desnorm_scheduler -- sequences one fixed->float conversion of a current/
// voltage sample pair through two independent datapath chains.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : desnorm_scheduler_if.slave (input handshake, datapath
//                control/results, output handshake)
// Flow: IDLE accepts a pair -> LAUNCH pulses begin_i/begin_v -> WAIT collects
// the two level ACKs (first ACK of each captured, later ones ignored) ->
// CLEAR pulses rst_dp -> OUT holds the result pair until out_ready.
// Optional watchdog: define DESNORM_TIMEOUT_EN to bound WAIT to TO_CYCLES
// cycles; on expiry the pair is flushed with timeout_err=1 and any result
// that never arrived reads as 0. Without the macro timeout_err is tied low.
module desnorm_scheduler #(
  parameter int W         = 32,
  parameter int TO_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  desnorm_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CLEAR,
    S_OUT
  } state_t;

  state_t       state, nxt;
  logic         done_i, done_v;
  logic [W-1:0] f_i_q, f_v_q;
  logic [W-1:0] out_i_q, out_v_q;
  logic         cap_i, cap_v;
  logic         all_done;
  logic         tmo_hit;
  logic         tmo_err;

  // First ACK of each chain in WAIT captures; the sticky flag blocks recapture.
  assign cap_i    = (state == S_WAIT) && bus.ack_i && !done_i;
  assign cap_v    = (state == S_WAIT) && bus.ack_v && !done_v;
  // Includes ACKs arriving this cycle so a simultaneous finish exits at once.
  assign all_done = (done_i || bus.ack_i) && (done_v || bus.ack_v);

`ifdef DESNORM_TIMEOUT_EN
  localparam int CW = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);
  logic [CW-1:0] cnt;

  // cnt holds the number of WAIT cycles already spent, so the expiry fires
  // at the end of the TO_CYCLES-th WAIT cycle. A finish on that same cycle
  // wins over the timeout.
  assign tmo_hit = (state == S_WAIT) && !all_done && (cnt == CW'(TO_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      tmo_err <= 1'b0;
    end else begin
      case (state)
        S_LAUNCH: begin
          cnt     <= '0;
          tmo_err <= 1'b0;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (tmo_hit) tmo_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (bus.in_valid) nxt = S_LAUNCH;
      S_LAUNCH: nxt = S_WAIT;
      S_WAIT:   if (all_done || tmo_hit) nxt = S_CLEAR;
      S_CLEAR:  nxt = S_OUT;
      S_OUT:    if (bus.out_ready) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_i  <= 1'b0;
      done_v  <= 1'b0;
      f_i_q   <= '0;
      f_v_q   <= '0;
      out_i_q <= '0;
      out_v_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            f_i_q <= bus.i_fix;
            f_v_q <= bus.v_fix;
          end
        end
        S_LAUNCH: begin
          // Zeroing the result registers here makes a chain that never
          // answers (watchdog flush) report 0 instead of a stale value.
          done_i  <= 1'b0;
          done_v  <= 1'b0;
          out_i_q <= '0;
          out_v_q <= '0;
        end
        S_WAIT: begin
          if (cap_i) begin
            out_i_q <= bus.result_i;
            done_i  <= 1'b1;
          end
          if (cap_v) begin
            out_v_q <= bus.result_v;
            done_v  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by rst_n because the state register already reads IDLE
  // while reset is still asserted.
  assign bus.in_ready    = rst_n && (state == S_IDLE);
  assign bus.begin_i     = (state == S_LAUNCH);
  assign bus.begin_v     = (state == S_LAUNCH);
  // Datapath is also held in reset whenever the scheduler itself is.
  assign bus.rst_dp      = !rst_n || (state == S_CLEAR);
  assign bus.out_valid   = (state == S_OUT);
  assign bus.f_i         = f_i_q;
  assign bus.f_v         = f_v_q;
  assign bus.out_i       = out_i_q;
  assign bus.out_v       = out_v_q;
  assign bus.timeout_err = tmo_err;

endmodule

// File: doc/desnorm_scheduler.md
DESNORM_SCHEDULER -- requirements
Module: desnorm_scheduler

Interface
REQ-001 Parameter W, default 32: width of the fixed-point sample and floating-point result words.
REQ-002 Parameter TO_CYCLES, default 1023: watchdog limit in CLK cycles; used only when DESNORM_TIMEOUT_EN is defined.
REQ-003 CLK  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 IN_VALID  in  1  sample pair on I_FIX/V_FIX is valid.
REQ-006 IN_READY  out  1  scheduler accepts a sample pair.
REQ-007 I_FIX  in  W  fixed-point current sample.
REQ-008 V_FIX  in  W  fixed-point voltage sample.
REQ-009 F_I  out  W  registered current operand to the datapath.
REQ-010 F_V  out  W  registered voltage operand to the datapath.
REQ-011 BEGIN_I  out  1  start pulse for the current conversion chain.
REQ-012 BEGIN_V  out  1  start pulse for the voltage conversion chain.
REQ-013 RST_DP  out  1  active-high reset to the datapath FSMs.
REQ-014 ACK_I  in  1  current chain done; level, held until RST_DP.
REQ-015 ACK_V  in  1  voltage chain done; level, held until RST_DP.
REQ-016 RESULT_I  in  W  current result, valid while ACK_I=1.
REQ-017 RESULT_V  in  W  voltage result, valid while ACK_V=1.
REQ-018 OUT_VALID  out  1  result pair is valid.
REQ-019 OUT_READY  in  1  consumer accepts the result pair.
REQ-020 OUT_I  out  W  captured current result.
REQ-021 OUT_V  out  W  captured voltage result.
REQ-022 TIMEOUT_ERR  out  1  the current OUT pair was produced by a watchdog expiry.

Function
REQ-023 FSM states: IDLE, LAUNCH, WAIT, CLEAR, OUT; exactly one active.
REQ-024 IDLE: IN_READY=1. When IN_VALID=1 the FSM SHALL load I_FIX->F_I and V_FIX->F_V, then go to LAUNCH. IN_READY=0 in all other states.
REQ-025 LAUNCH: lasts one cycle. BEGIN_I=BEGIN_V=1 in this cycle only. Then WAIT; the sticky flags DONE_I and DONE_V clear on entry.
REQ-026 WAIT, ACK_I: on the first cycle ACK_I=1, capture RESULT_I->OUT_I and set DONE_I. Later ACK_I cycles SHALL NOT recapture. ACK_V/RESULT_V/DONE_V behave identically.
REQ-027 WAIT, exit: ACKs may arrive in either order or in the same cycle. When DONE_I&DONE_V (including the flags set in the current cycle), go to CLEAR.
REQ-028 CLEAR: lasts one cycle. RST_DP=1, then OUT.
REQ-029 OUT: OUT_VALID=1. OUT_I/OUT_V/TIMEOUT_ERR held stable until OUT_READY=1, then IDLE. OUT_VALID=0 in all other states.
REQ-030 Latency: OUT_VALID rises exactly 2 cycles after the cycle in which the later ACK is first sampled high.
REQ-031 F_I/F_V SHALL hold from load until the next IDLE acceptance.
REQ-032 Stray ACK_I/ACK_V outside WAIT SHALL be ignored.
REQ-033 Back-to-back operation: a new pair is accepted only in IDLE, so at most one pair is in flight.

Reset
REQ-034 RST_N=0 SHALL immediately force IDLE, clear DONE flags, watchdog, F_I, F_V, OUT_I, OUT_V to 0, and drive IN_READY=0, BEGIN_I=BEGIN_V=0, OUT_VALID=0, TIMEOUT_ERR=0.
REQ-035 RST_DP=1 combinationally while RST_N=0 (in addition to CLEAR), so a mid-conversion reset also clears the datapath. After RST_N deasserts, IN_READY=1 from the first clock edge.

Configuration
REQ-036 With DESNORM_TIMEOUT_EN defined: a counter clears in LAUNCH and increments each WAIT cycle. If it reaches TO_CYCLES before both DONE flags are set, go to CLEAR with TIMEOUT_ERR=1, and any missing OUT_I/OUT_V is 0. TIMEOUT_ERR clears on entry to LAUNCH.
REQ-037 Without DESNORM_TIMEOUT_EN: no counter is present, WAIT lasts indefinitely, and TIMEOUT_ERR is tied to 0.

Verification
REQ-038 I_FIX=0x00010000, V_FIX=0x00020000. ACK_I at WAIT cycle 5 (RESULT_I=0x3F800000), ACK_V at cycle 9 (RESULT_V=0x40000000) -> one BEGIN pulse each, one RST_DP pulse, OUT_VALID 2 cycles after ACK_V, OUT_I=0x3F800000, OUT_V=0x40000000.
REQ-039 ACK_V before ACK_I, then both in the same cycle -> correct capture in both orders; OUT_VALID 2 cycles after the later/common ACK.
REQ-040 OUT_READY held 0 for 10 cycles while IN_VALID=1 -> OUT_* stable, IN_READY=0, no new BEGIN until the OUT handshake completes.
REQ-041 RST_N pulsed low in WAIT -> RST_DP=1 during reset, all outputs 0, IDLE with IN_READY=1 after release, and a subsequent pair completes normally.
REQ-042 DESNORM_TIMEOUT_EN defined, TO_CYCLES=16, ACK_I only (RESULT_I=0x3F800000) -> CLEAR after 16 WAIT cycles, TIMEOUT_ERR=1, OUT_I=0x3F800000, OUT_V=0. The next good pair gives TIMEOUT_ERR=0.
